pcs_line_impairment: RTL and testbench

- Parametrised line-side impairment block for 10GBASE-R PCS line-loopback benches and on-chip self-test.
- Sits between serdes_tx_data/serdes_tx_hdr of one eth_phy_10g and serdes_rx_data/serdes_rx_hdr of another, or the same one in loopback.
- Replaces hard-coded header-corruption stimulus with programmable injection: periodic or one-shot bursts of invalid sync headers, swapped headers or data bit flips, plus a programmable line delay.
- Keeps saturating counts of blocks passed and blocks corrupted.

---
 rtl/pcs_impair_pkg.sv | 21 ++
 rtl/pcs_impair_delay_line.sv | 36 +++
 rtl/pcs_line_impairment.sv | 187 ++++++++++++++++++
 tb/tb_pcs_line_impairment.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_impair_pkg.sv
// Shared encodings for the PCS line-impairment block: injection modes,
// sequencer states and the two legal 10GBASE-R sync headers.
package pcs_impair_pkg;

    typedef enum logic [1:0] {
        MODE_PASS      = 2'd0,
        MODE_HDR_FORCE = 2'd1,
        MODE_HDR_INV   = 2'd2,
        MODE_DATA_XOR  = 2'd3
    } impair_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } impair_state_e;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

endpackage

// File: rtl/pcs_impair_delay_line.sv
// Fixed-depth register chain with a selectable output tap. Stage 0 is always
// present, so tap N gives N+1 cycles of latency.
module pcs_impair_delay_line #(
    parameter int WIDTH = 67,
    parameter int DEPTH = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_din,
    input  logic [SEL_W-1:0] i_tap,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift every block one stage down the chain each cycle.
    // NOTE: this chain is reset stage by stage on purpose; it is a pipeline
    // whose contents reach the outputs, not a RAM, so stale blocks must not
    // survive a reset. Sequential state uses <= so all stages shift together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    // Select the requested tap; out-of-range taps clamp to the last stage.
    always_comb begin
        if (int'(i_tap) < DEPTH) o_dout = r_stage[i_tap];
        else                     o_dout = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/pcs_line_impairment.sv
// Line-side impairment between a 10GBASE-R TX SERDES interface and an RX one.
// A small sequencer counts valid blocks through a programmable period and
// corrupts the first cfg_burst of them (header force, header invert or data
// XOR), then the result goes through a 1 + cfg_delay cycle delay line.
// Saturating counters track blocks forwarded and blocks corrupted.
module pcs_line_impairment #(
    parameter int DATA_WIDTH   = 64,
    parameter int HDR_WIDTH    = 2,
    parameter int DELAY_MAX    = 8,
    parameter int PERIOD_WIDTH = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [HDR_WIDTH-1:0]          in_hdr,
    input  logic                          in_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [HDR_WIDTH-1:0]          out_hdr,
    output logic                          out_valid,
    input  logic                          cfg_enable,
    input  logic [1:0]                    cfg_mode,
    input  logic [HDR_WIDTH-1:0]          cfg_hdr_value,
    input  logic [DATA_WIDTH-1:0]         cfg_mask,
    input  logic [PERIOD_WIDTH-1:0]       cfg_period,
    input  logic [PERIOD_WIDTH-1:0]       cfg_burst,
    input  logic                          cfg_oneshot,
    input  logic [$clog2(DELAY_MAX)-1:0]  cfg_delay,
    input  logic                          cfg_clear,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_WIDTH-1:0]          blk_count,
    output logic [CNT_WIDTH-1:0]          err_count
);

    import pcs_impair_pkg::*;

    localparam int DLY_W  = $clog2(DELAY_MAX);
    localparam int LINE_W = 1 + HDR_WIDTH + DATA_WIDTH;

    impair_state_e           r_state, w_state_nxt;
    impair_mode_e            r_mode;
    logic [HDR_WIDTH-1:0]    r_hdr_value;
    logic [DATA_WIDTH-1:0]   r_mask;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH-1:0] r_burst;
    logic                    r_oneshot;
    logic [DLY_W-1:0]        r_delay;
    logic [PERIOD_WIDTH-1:0] r_idx, w_idx_nxt;
    logic [CNT_WIDTH-1:0]    r_blk_count, r_err_count;

    logic                    w_load_cfg;
    logic [PERIOD_WIDTH-1:0] w_period_m1;
    logic                    w_idx_last;
    logic                    w_corrupt;
    logic [HDR_WIDTH-1:0]    w_imp_hdr;
    logic [DATA_WIDTH-1:0]   w_imp_data;
    logic [LINE_W-1:0]       w_line_out;

    // A period of 0 behaves as a period of 1.
    assign w_period_m1 = (r_period == '0) ? '0 : r_period - PERIOD_WIDTH'(1);
    assign w_idx_last  = (r_idx >= w_period_m1);

    // Only valid blocks inside the burst window of a running period are hit.
    assign w_corrupt = (r_state == RUN) && in_valid && (r_idx < r_burst)
                       && (r_mode != MODE_PASS);

    // Sequencer state and period index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state logic: arm on enable, walk the period on valid blocks,
    // stop after one period in one-shot mode, disarm when enable drops.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load_cfg  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cfg_enable) begin
                    w_state_nxt = RUN;
                    w_idx_nxt   = '0;
                    w_load_cfg  = 1'b1;
                end
            end
            RUN: begin
                if (!cfg_enable) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end else if (in_valid) begin
                    if (w_idx_last) begin
                        w_idx_nxt = '0;
                        if (r_oneshot) w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + PERIOD_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (!cfg_enable) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Configuration snapshot taken when the sequencer arms.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode      <= MODE_PASS;
            r_hdr_value <= '0;
            r_mask      <= '0;
            r_period    <= '0;
            r_burst     <= '0;
            r_oneshot   <= 1'b0;
            r_delay     <= '0;
        end else if (w_load_cfg) begin
            r_mode      <= impair_mode_e'(cfg_mode);
            r_hdr_value <= cfg_hdr_value;
            r_mask      <= cfg_mask;
            r_period    <= cfg_period;
            r_burst     <= cfg_burst;
            r_oneshot   <= cfg_oneshot;
            r_delay     <= cfg_delay;
        end
    end

    // Apply the selected impairment to the incoming block.
    always_comb begin
        w_imp_hdr  = in_hdr;
        w_imp_data = in_data;
        if (w_corrupt) begin
            unique case (r_mode)
                MODE_HDR_FORCE: w_imp_hdr  = r_hdr_value;
                MODE_HDR_INV:   w_imp_hdr  = ~in_hdr;
                MODE_DATA_XOR:  w_imp_data = in_data ^ r_mask;
                default:        w_imp_hdr  = in_hdr;
            endcase
        end
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || cfg_clear) begin
            r_blk_count <= '0;
            r_err_count <= '0;
        end else begin
            if (in_valid && (r_blk_count != '1))
                r_blk_count <= r_blk_count + CNT_WIDTH'(1);
            if (w_corrupt && (r_err_count != '1))
                r_err_count <= r_err_count + CNT_WIDTH'(1);
        end
    end

    pcs_impair_delay_line #(
        .WIDTH (LINE_W),
        .DEPTH (DELAY_MAX),
        .SEL_W (DLY_W)
    ) u_delay_line (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  ({in_valid, w_imp_hdr, w_imp_data}),
        .i_tap  (r_delay),
        .o_dout (w_line_out)
    );

    assign {out_valid, out_hdr, out_data} = w_line_out;
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign blk_count = r_blk_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_pcs_line_impairment.sv
// Bench for pcs_line_impairment. Two instances share all inputs: one with
// 32-bit counters and one with 4-bit counters so saturation is reachable.
// A reference model (position-in-period counter plus a history queue of
// output blocks) is checked every cycle; directed steps add literal checks.
module tb_pcs_line_impairment;

    localparam int DW = 64;
    localparam int DM = 8;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic [1:0]    in_hdr;
    logic          in_valid;
    logic          cfg_enable;
    logic [1:0]    cfg_mode;
    logic [1:0]    cfg_hdr_value;
    logic [DW-1:0] cfg_mask;
    logic [15:0]   cfg_period;
    logic [15:0]   cfg_burst;
    logic          cfg_oneshot;
    logic [2:0]    cfg_delay;
    logic          cfg_clear;

    logic [DW-1:0] out_data,  s_out_data;
    logic [1:0]    out_hdr,   s_out_hdr;
    logic          out_valid, s_out_valid;
    logic          busy,      s_busy;
    logic          done,      s_done;
    logic [31:0]   blk_count, err_count;
    logic [3:0]    s_blk_count, s_err_count;

    pcs_line_impairment dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_hdr(in_hdr), .in_valid(in_valid),
        .out_data(out_data), .out_hdr(out_hdr), .out_valid(out_valid),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_hdr_value(cfg_hdr_value),
        .cfg_mask(cfg_mask), .cfg_period(cfg_period), .cfg_burst(cfg_burst),
        .cfg_oneshot(cfg_oneshot), .cfg_delay(cfg_delay), .cfg_clear(cfg_clear),
        .busy(busy), .done(done), .blk_count(blk_count), .err_count(err_count)
    );

    pcs_line_impairment #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_hdr(in_hdr), .in_valid(in_valid),
        .out_data(s_out_data), .out_hdr(s_out_hdr), .out_valid(s_out_valid),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_hdr_value(cfg_hdr_value),
        .cfg_mask(cfg_mask), .cfg_period(cfg_period), .cfg_burst(cfg_burst),
        .cfg_oneshot(cfg_oneshot), .cfg_delay(cfg_delay), .cfg_clear(cfg_clear),
        .busy(s_busy), .done(s_done), .blk_count(s_blk_count), .err_count(s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint n, input int w);
        longint top;
        top = longint'((64'd1 << w) - 64'd1);
        return (n > top) ? top : n;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          v;
        logic [1:0]    h;
        logic [DW-1:0] d;
    } blk_t;

    blk_t          hist[$];   // newest output block at index 0
    blk_t          m_b, m_e;
    bit            m_armed, m_finished, m_hit;
    int            m_pos, m_p, m_skip;
    longint        m_blk, m_err;
    int            c_mode, c_period, c_burst, c_delay;
    logic [1:0]    c_hdr;
    logic [DW-1:0] c_mask;
    bit            c_oneshot;

    always begin
        @(posedge clk);
        if (!rst_n) begin
            hist.delete();
            for (int i = 0; i < DM; i++) hist.push_back('0);
            m_armed = 0; m_finished = 0; m_pos = 0; m_blk = 0; m_err = 0;
            c_mode = 0; c_delay = 0; c_period = 0; c_burst = 0;
            c_hdr = '0; c_mask = '0; c_oneshot = 0; m_skip = 0;
        end else begin
            m_p   = (c_period == 0) ? 1 : c_period;
            m_hit = m_armed && !m_finished && in_valid && (m_pos < c_burst) && (c_mode != 0);
            m_b.v = in_valid; m_b.h = in_hdr; m_b.d = in_data;
            if (m_hit) begin
                if (c_mode == 1) m_b.h = c_hdr;
                if (c_mode == 2) m_b.h = ~in_hdr;
                if (c_mode == 3) m_b.d = in_data ^ c_mask;
            end
            hist.push_front(m_b);
            void'(hist.pop_back());
            if (cfg_clear) begin
                m_blk = 0; m_err = 0;
            end else begin
                m_blk += longint'(in_valid);
                m_err += longint'(m_hit);
            end
            if (!m_armed) begin
                if (cfg_enable) begin
                    m_armed = 1; m_finished = 0; m_pos = 0;
                    c_mode = int'(cfg_mode); c_hdr = cfg_hdr_value; c_mask = cfg_mask;
                    c_period = int'(cfg_period); c_burst = int'(cfg_burst);
                    c_oneshot = cfg_oneshot;
                    if (int'(cfg_delay) != c_delay) m_skip = DM;
                    c_delay = int'(cfg_delay);
                end
            end else if (!cfg_enable) begin
                m_armed = 0; m_finished = 0; m_pos = 0;
            end else if (!m_finished && in_valid) begin
                m_pos++;
                if (m_pos == m_p) begin
                    m_pos = 0;
                    if (c_oneshot) m_finished = 1;
                end
            end
        end
        #1;
        m_e = hist[c_delay];
        if (m_skip == 0) begin
            check("out_valid", 64'(out_valid), 64'(m_e.v));
            check("sat.out_valid", 64'(s_out_valid), 64'(m_e.v));
            if (m_e.v) begin
                check("out_data", out_data, m_e.d);
                check("out_hdr", 64'(out_hdr), 64'(m_e.h));
                check("sat.out_data", s_out_data, m_e.d);
                check("sat.out_hdr", 64'(s_out_hdr), 64'(m_e.h));
            end
        end else begin
            m_skip--;
        end
        check("busy", 64'(busy), 64'(m_armed && !m_finished));
        check("done", 64'(done), 64'(m_finished));
        check("sat.busy", 64'(s_busy), 64'(m_armed && !m_finished));
        check("sat.done", 64'(s_done), 64'(m_finished));
        check("blk_count", 64'(blk_count), 64'(sat(m_blk, 32)));
        check("err_count", 64'(err_count), 64'(sat(m_err, 32)));
        check("sat.blk_count", 64'(s_blk_count), 64'(sat(m_blk, 4)));
        check("sat.err_count", 64'(s_err_count), 64'(sat(m_err, 4)));
    end

    // ---------------- directed stimulus ----------------
    // Inputs change on the falling edge; after apply() returns the block has
    // been taken by one rising edge and the outputs have settled.
    task automatic apply(input logic v, input logic [1:0] h, input logic [DW-1:0] d);
        in_valid = v; in_hdr = h; in_data = d;
        @(negedge clk);
    endtask

    task automatic arm(input logic [1:0] mode, input logic [1:0] hv, input logic [DW-1:0] mask,
                       input int period, input int burst, input logic oneshot, input int dly);
        cfg_enable = 1'b0;
        apply(1'b0, 2'b10, '0);
        cfg_mode = mode; cfg_hdr_value = hv; cfg_mask = mask;
        cfg_period = 16'(period); cfg_burst = 16'(burst);
        cfg_oneshot = oneshot; cfg_delay = 3'(dly);
        cfg_enable = 1'b1; cfg_clear = 1'b1;
        apply(1'b0, 2'b10, '0);
        cfg_clear = 1'b0;
    endtask

    logic [DW-1:0] pats [6];
    logic [1:0]    hdr_i;
    logic [DW-1:0] dat_i;
    int            vcnt;

    initial begin
        pats[0] = 64'hFFFF_FFFF_FFFF_FFFF; pats[1] = 64'h0000_0000_0000_0000;
        pats[2] = 64'h5555_5555_5555_5555; pats[3] = 64'hAAAA_AAAA_AAAA_AAAA;
        pats[4] = 64'hFEFE_FEFE_FEFE_FEFE; pats[5] = 64'h0707_0707_0707_0707;

        rst_n = 1'b0; in_valid = 1'b0; in_hdr = '0; in_data = '0;
        cfg_enable = 1'b0; cfg_mode = '0; cfg_hdr_value = '0; cfg_mask = '0;
        cfg_period = '0; cfg_burst = '0; cfg_oneshot = 1'b0; cfg_delay = '0; cfg_clear = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst out_data", out_data, 64'h0);
        check("rst out_valid", 64'(out_valid), 64'h0);
        check("rst busy", 64'(busy), 64'h0);
        check("rst blk_count", 64'(blk_count), 64'h0);
        rst_n = 1'b1;

        // Idle pass-through, one cycle of latency, bubble propagates.
        for (int i = 0; i < 12; i++) begin
            apply(1'b1, 2'b10, 64'h0707_0707_0707_0707);
            check("pass data", out_data, 64'h0707_0707_0707_0707);
            check("pass hdr", 64'(out_hdr), 64'h2);
        end
        apply(1'b0, 2'b10, 64'h0707_0707_0707_0707);
        check("pass bubble", 64'(out_valid), 64'h0);
        check("pass blk_count", 64'(blk_count), 64'd12);
        check("pass err_count", 64'(err_count), 64'd0);

        // Header force, period 11, burst 1.
        arm(2'd1, 2'b00, '0, 11, 1, 1'b0, 0);
        check("m1 busy", 64'(busy), 64'h1);
        for (int i = 0; i < 110; i++) begin
            apply(1'b1, 2'b10, 64'(i));
            if (i == 0)  check("m1 first hdr", 64'(out_hdr), 64'h0);
            if (i == 1)  check("m1 second hdr", 64'(out_hdr), 64'h2);
            if (i == 11) check("m1 12th hdr", 64'(out_hdr), 64'h0);
        end
        check("m1 err_count", 64'(err_count), 64'd10);
        check("m1 blk_count", 64'(blk_count), 64'd110);
        check("m1 sat blk_count", 64'(s_blk_count), 64'd15);

        // Header invert, one-shot, period 64, burst 16.
        arm(2'd2, 2'b00, '0, 64, 16, 1'b1, 0);
        for (int i = 0; i < 80; i++) begin
            hdr_i = i[0] ? 2'b01 : 2'b10;
            apply(1'b1, hdr_i, 64'(i) << 8);
            if (i == 0)  check("m2 first hdr", 64'(out_hdr), 64'h1);
            if (i == 15) check("m2 16th hdr", 64'(out_hdr), 64'h2);
            if (i == 16) check("m2 17th hdr", 64'(out_hdr), 64'h2);
        end
        check("m2 done", 64'(done), 64'h1);
        check("m2 busy", 64'(busy), 64'h0);
        check("m2 err_count", 64'(err_count), 64'd16);
        cfg_enable = 1'b0;
        apply(1'b0, 2'b10, '0);
        check("m2 done drops", 64'(done), 64'h0);

        // Data XOR, period 4, burst 4, alternating bubbles.
        arm(2'd3, 2'b00, 64'h1, 4, 4, 1'b0, 0);
        for (int i = 0; i < 16; i++) begin
            dat_i = 64'hA5A5_A5A5_A5A5_A5A4 + 64'(i * 2);
            apply(i % 2 == 0, 2'b10, dat_i);
            if (i % 2 == 0) check("m3 bit0 flip", out_data, dat_i ^ 64'h1);
            else            check("m3 bubble", 64'(out_valid), 64'h0);
        end
        check("m3 err_count", 64'(err_count), 64'd8);
        check("m3 blk_count", 64'(blk_count), 64'd8);

        // Data XOR, period 4, burst 2: index advances on valid blocks only.
        arm(2'd3, 2'b00, 64'h1, 4, 2, 1'b0, 0);
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            dat_i = 64'h1234_5678_0000_0000 + 64'(i * 2);
            apply(i % 2 == 0, 2'b10, dat_i);
            if (i % 2 == 0) begin
                check("m3b pattern", out_data, ((vcnt % 4) < 2) ? (dat_i ^ 64'h1) : dat_i);
                vcnt++;
            end
        end
        check("m3b err_count", 64'(err_count), 64'd4);

        // Delay 5: each pattern emerges 6 cycles after it is applied.
        arm(2'd0, 2'b00, '0, 1, 0, 1'b0, 5);
        repeat (DM) apply(1'b0, 2'b10, '0);
        for (int j = 0; j < 11; j++) begin
            if (j < 6) apply(1'b1, 2'b10, pats[j]);
            else       apply(1'b0, 2'b10, '0);
            if (j == 4) check("dly not yet", 64'(out_valid), 64'h0);
            if (j >= 5) begin
                check("dly data", out_data, pats[j-5]);
                check("dly valid", 64'(out_valid), 64'h1);
            end
        end

        // Saturation on the 4-bit instance, clear priority, reset mid-burst.
        arm(2'd1, 2'b11, '0, 2, 2, 1'b0, 0);
        repeat (DM) apply(1'b0, 2'b10, '0);
        for (int i = 0; i < 20; i++) apply(1'b1, 2'b10, 64'(i));
        check("sat err_count", 64'(s_err_count), 64'd15);
        check("sat blk_count", 64'(s_blk_count), 64'd15);
        check("wide err_count", 64'(err_count), 64'd20);
        cfg_clear = 1'b1;
        apply(1'b1, 2'b10, 64'h99);
        cfg_clear = 1'b0;
        check("clear err_count", 64'(s_err_count), 64'd0);
        check("clear blk_count", 64'(s_blk_count), 64'd0);
        repeat (3) apply(1'b1, 2'b10, 64'h77);
        check("post-clear err", 64'(s_err_count), 64'd3);
        rst_n = 1'b0;
        apply(1'b1, 2'b10, 64'h55);
        check("mid rst out_data", out_data, 64'h0);
        check("mid rst out_hdr", 64'(out_hdr), 64'h0);
        check("mid rst out_valid", 64'(out_valid), 64'h0);
        check("mid rst busy", 64'(busy), 64'h0);
        check("mid rst err_count", 64'(err_count), 64'h0);
        rst_n = 1'b1;
        cfg_enable = 1'b0;
        repeat (4) apply(1'b1, 2'b01, 64'h42);
        check("after rst pass hdr", 64'(out_hdr), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
